char_buffer_ctrl: RTL
=====================

Name: char_buffer_ctrl

Overview:
- Owns the 80x60 text-mode character RAM (one byte per 8x8 cell, 640x480 active area) and schedules its single port.
- Supplies the per-pixel ASCII code to the character identification stage (which renders via chargenrom).
- Arbitrates the port between display prefetch, a screen-clear sweeper and a buffered writer port from game/user logic.

Parameters:
- FIFO_DEPTH, 4, writer request queue depth (power of two, >=2).
- FILL_CHAR, 8'h20, code written by clear sweep.
- BLINK_FRAMES, 30, frames per cursor blink phase (CURSOR_EN only).

Ports:
- vgaclk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- x  in  10  horizontal pixel counter from VGA timing (0..799).
- y  in  10  vertical line counter (0..524).
- char_code  out  8  ASCII code of the cell under (x,y).
- wr_req  in  1  writer request.
- wr_col  in  7  target column.
- wr_row  in  6  target row.
- wr_data  in  8  code to write.
- wr_ack  out  1  one-cycle pulse: request consumed.
- wr_drop  out  1  one-cycle pulse: consumed request was out of range and discarded.
- clr_req  in  1  start clear-screen sweep.
- busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse at sweep end.
- cursor_col  in  7  cursor column (ignored without CURSOR_EN).
- cursor_row  in  6  cursor row (ignored without CURSOR_EN).

Behaviour:
- Active area: 145<=x<=784, 35<=y<=514. Cell col=(x-145)>>3, row=(y-35)>>3. RAM address = row*80+col (13 bits, 0..4799).
- RAM: synchronous read, 1-cycle latency, single port.
- Display slot: any cycle with 35<=y<=514 and x=143+8k, k=0..79. Port reads cell (row,k) in that slot. Result lands in the char_code register so char_code is valid for x=145+8k..152+8k.
- Outside the active area, char_code = 8'h41.
- Port priority in non-display cycles: clear sweep > FIFO drain. One RAM access per cycle.
- Writer: wr_ack pulses the cycle after wr_req is sampled with the FIFO not full. Requests seen while the FIFO is full are not acked; the writer holds wr_req until acked.
- A request with col>=80 or row>=60 is acked with wr_drop=1 the same cycle and is never enqueued.
- FIFO drains one entry per free cycle, in order.
- FSM states:
  - IDLE -> CLEAR on clr_req. In CLEAR, busy=1.
  - CLEAR writes FILL_CHAR to addresses 0..4799 ascending, one per free cycle.
  - After address 4799 is written: clr_done pulses, busy drops the next cycle, FSM returns to IDLE.
  - clr_req while in CLEAR is ignored.
  - FIFO accepts writes during CLEAR but drains only after it. Writes queued during a clear therefore survive it.
- Simultaneous events:
  - clr_req and wr_req in the same cycle: both are accepted.
  - Display slot coinciding with a pending write: write waits.
  - A display read in the same slot as a queued write to the same cell returns the old value.
- Reset, including mid-sweep:
  - char_code=8'h41, wr_ack=0, wr_drop=0, busy=0, clr_done=0, FIFO empty, FSM IDLE, blink counter 0.
  - RAM contents are not reset. An aborted sweep leaves the RAM partially cleared.

Optional Feature:
- Macro CURSOR_EN.
- Defined:
  - Frame counter increments at x=0,y=0.
  - Blink phase toggles every BLINK_FRAMES frames and starts off after reset.
  - While the phase is on, char_code is forced to 8'hDB for the cell at (cursor_col,cursor_row). Same display timing; RAM is untouched.
- Undefined: cursor ports unused, no counter, char_code always from RAM.

Test Plan:
- Reset, then scan a full frame with the RAM holding address-mod-256 pattern -> char_code at x=145,y=35 is 8'h00; at x=153 it is 8'h01; at x=100 it is 8'h41.
- wr_req col=5,row=2,data=8'h4B during active video -> wr_ack one cycle later; next frame, cell (5,2) (x=185..192, y=51..58) shows 8'h4B.
- Five back-to-back wr_req, FIFO_DEPTH=4, driven during the x=143 display slot -> fifth not acked until a drain. All five land in order, and no display read is skipped.
- wr_req col=80,row=0 -> wr_ack and wr_drop both pulse; RAM unchanged.
- clr_req, then wr_req (3,3,8'h58) during the sweep -> busy high until clr_done. Afterwards every cell is 8'h20 except (3,3)=8'h58. A second clr_req mid-sweep has no effect.
- CURSOR_EN, BLINK_FRAMES=2, cursor (0,0) -> cell (0,0) shows 8'hDB in frames 2-3 and RAM value in frames 0-1 and 4-5; assert reset mid-frame -> counter restarts at 0.

Source files
------------

// File: rtl/char_buffer_ctrl.sv
// char_buffer_ctrl
// Owns the 80x60 text-mode character RAM and schedules its single port.
// Display prefetch always wins its slot. Other cycles go first to the
// clear sweeper and then to the writer FIFO.
// Optional feature: define CURSOR_EN to add a blinking block cursor overlay.
module char_buffer_ctrl #(
  parameter int         FIFO_DEPTH   = 4,
  parameter logic [7:0] FILL_CHAR    = 8'h20,
  parameter int         BLINK_FRAMES = 30
) (
  input  logic       vgaclk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic [7:0] char_code,
  input  logic       wr_req,
  input  logic [6:0] wr_col,
  input  logic [5:0] wr_row,
  input  logic [7:0] wr_data,
  output logic       wr_ack,
  output logic       wr_drop,
  input  logic       clr_req,
  output logic       busy,
  output logic       clr_done,
  input  logic [6:0] cursor_col,
  input  logic [5:0] cursor_row
);

  localparam int          CELLS     = 4800;
  localparam logic [12:0] LAST_ADDR = 13'(CELLS - 1);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE   = 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state;
  logic [12:0] clr_addr;

  // ---------------------------------------------------------------
  // Display timing: the slot at x=143+8k reads cell k of the current
  // row; the RAM word appears at x=144+8k and is registered into
  // char_code at the end of that cycle, so it is shown on 145+8k..152+8k.
  // ---------------------------------------------------------------
  logic        y_active;
  logic        slot;
  logic        load_win;
  logic        load_now;
  logic [6:0]  disp_col;
  logic [5:0]  disp_row;
  logic [12:0] disp_addr;

  assign y_active  = (y >= 10'd35) && (y <= 10'd514);
  assign slot      = y_active && (x >= 10'd143) && (x <= 10'd775) && (x[2:0] == 3'b111);
  assign load_win  = y_active && (x >= 10'd144) && (x <= 10'd783);
  assign load_now  = load_win && (x[2:0] == 3'b000);
  assign disp_col  = 7'((x - 10'd143) >> 3);
  assign disp_row  = 6'((y - 10'd35) >> 3);
  assign disp_addr = ({7'd0, disp_row} * 13'd80) + {6'd0, disp_col};

  // ---------------------------------------------------------------
  // Writer request FIFO
  // ---------------------------------------------------------------
  logic [12:0] fifo_addr [FIFO_DEPTH];
  logic [7:0]  fifo_data [FIFO_DEPTH];
  logic [PW:0] wptr;
  logic [PW:0] rptr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        accept;
  logic        in_range;
  logic        push;
  logic        pop;
  logic [12:0] wr_addr;

  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign in_range   = (wr_col < 7'd80) && (wr_row < 6'd60);
  assign accept     = wr_req && !fifo_full;
  assign push       = accept && in_range;
  assign wr_addr    = ({7'd0, wr_row} * 13'd80) + {6'd0, wr_col};
  // The FIFO is held back for the whole sweep so queued writes land on top of it.
  assign pop        = (state == IDLE) && !slot && !fifo_empty;

  // Store accepted in-range requests (payload only, no reset needed)
  always_ff @(posedge vgaclk) begin
    if (push) begin
      fifo_addr[wptr[PW-1:0]] <= wr_addr;
      fifo_data[wptr[PW-1:0]] <= wr_data;
    end
  end

  // FIFO pointers and the ack/drop pulses for consumed requests
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      wr_ack  <= 1'b0;
      wr_drop <= 1'b0;
    end else begin
      wr_ack  <= accept;
      wr_drop <= accept && !in_range;
      if (push) wptr <= wptr + PTR_ONE;
      if (pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // ---------------------------------------------------------------
  // Port arbitration: display slot > clear sweep > FIFO drain
  // ---------------------------------------------------------------
  logic        clr_we;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;

  assign clr_we = (state == CLEAR) && !slot;

  // Select address and write data for the single RAM port
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = disp_addr;
    ram_wdata = fifo_data[rptr[PW-1:0]];
    if (!slot) begin
      if (clr_we) begin
        ram_we    = 1'b1;
        ram_addr  = clr_addr;
        ram_wdata = FILL_CHAR;
      end else if (pop) begin
        ram_we    = 1'b1;
        ram_addr  = fifo_addr[rptr[PW-1:0]];
      end
    end
  end

  // ---------------------------------------------------------------
  // Character RAM: single port, registered read, contents never reset
  // ---------------------------------------------------------------
  logic [7:0] mem [CELLS];
  logic [7:0] ram_q;

  // Write on arbitrated cycles, read only in display slots
  always_ff @(posedge vgaclk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end else if (slot) begin
      ram_q <= mem[ram_addr];
    end
  end

  // Clear-sweep FSM with registered busy/clr_done
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      clr_addr <= '0;
      busy     <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
        CLEAR: begin
          // A new clr_req is ignored here; the sweep only advances on free cycles.
          if (clr_we) begin
            if (clr_addr == LAST_ADDR) begin
              state    <= IDLE;
              busy     <= 1'b0;
              clr_done <= 1'b1;
            end else begin
              clr_addr <= clr_addr + 13'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Cursor overlay
  // ---------------------------------------------------------------
  logic cursor_hit;

`ifdef CURSOR_EN
  localparam int          BW         = $clog2(BLINK_FRAMES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  localparam logic [BW-1:0] CNT_ONE    = 1;

  logic [BW-1:0] frame_cnt;
  logic          blink_on;
  logic          hit_reg;

  // Count frames at (0,0) and flip the blink phase every BLINK_FRAMES frames
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      blink_on  <= 1'b0;
    end else if ((x == 10'd0) && (y == 10'd0)) begin
      if (frame_cnt == BLINK_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + CNT_ONE;
      end
    end
  end

  // Remember whether the cell fetched in this slot is the cursor cell
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      hit_reg <= 1'b0;
    end else if (slot) begin
      hit_reg <= (disp_col == cursor_col) && (disp_row == cursor_row);
    end
  end

  assign cursor_hit = blink_on && hit_reg;
`else
  wire unused_cursor = ^{cursor_col, cursor_row};
  assign cursor_hit = 1'b0;
`endif

  // Present the fetched code inside the active area, 'A' elsewhere
  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      char_code <= 8'h41;
    end else if (load_now) begin
      char_code <= cursor_hit ? 8'hDB : ram_q;
    end else if (!load_win) begin
      char_code <= 8'h41;
    end
  end

endmodule
